// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: opcode/funct
// values, ALU commands, FSM state encoding and the bundle of control
// outputs produced in each state.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14,
    S_HALT     = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_cntrl;
    logic       mem_wr;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_dispatch.sv
// Instruction dispatch for the DECODE state: maps opcode/funct to the
// state that follows DECODE and flags encodings the controller does not
// implement. Purely combinational.
//   opcode_i      IR[31:26]
//   funct_i       IR[5:0]
//   next_state_o  successor of DECODE for a legal instruction (FETCH otherwise)
//   illegal_o     opcode/funct combination is not supported
module multicycle_ctrl_dispatch
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_e     next_state_o,
  output logic       illegal_o
);

  always_comb begin
    next_state_o = S_FETCH;
    illegal_o    = 1'b0;
    unique case (opcode_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADD || funct_i == FN_SUB || funct_i == FN_SLT) begin
          next_state_o = S_EXEC_R;
        end else if (funct_i == FN_JR) begin
          next_state_o = S_JR;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_ADDI, OP_XORI: next_state_o = S_EXEC_I;
      OP_LW, OP_SW:     next_state_o = S_MEM_ADDR;
      OP_BEQ, OP_BNE:   next_state_o = S_BRANCH;
      OP_J:             next_state_o = S_JUMP;
      OP_JAL:           next_state_o = S_JAL;
      default:          illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle CPU. One datapath phase per clock;
// every mux select and write enable comes from the current state, with the
// single exception of PCWr in BRANCH, which also looks at the zero flag.
//   clk, reset          system clock; asynchronous active-high reset
//   opcode, funct, zero instruction fields from the IR and ALU zero flag
//   PCWr .. PCSrc       datapath enables and selects
//   illegal             high while halted on an unsupported instruction
//   state               current state, debug only
//
// state    | meaning
// RESET    | idle after reset, all outputs 0
// FETCH    | read instruction at PC into IR, PC <= PC+4
// DECODE   | compute branch target into ALUOut, dispatch
// EXEC_R   | R-type ALU operation rs op rt
// WB_R     | write ALUOut to rd
// EXEC_I   | immediate ALU operation rs op imm
// WB_I     | write ALUOut to rt
// MEM_ADDR | effective address rs + imm
// MEM_RD   | load from ALUOut address into MDR
// WB_MEM   | write MDR to rt
// MEM_WR   | store rt to ALUOut address
// BRANCH   | compare rs/rt, conditionally load branch target
// JUMP     | PC <= jump address
// JAL      | PC <= jump address, r31 <= PC (already +4)
// JR       | PC <= rs
// HALT     | unsupported instruction, wait for reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUcntrl,
  output logic       MemWr,
  output logic [1:0] MemToReg,
  output logic [1:0] RegDst,
  output logic       RegWr,
  output logic [1:0] PCSrc,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  state_e disp_next;
  logic   disp_illegal;
  ctrl_t  ctrl;

  multicycle_ctrl_dispatch u_dispatch (
    .opcode_i     (opcode),
    .funct_i      (funct),
    .next_state_o (disp_next),
    .illegal_o    (disp_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (disp_illegal) state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        else              state_d = disp_next;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR,
      S_BRANCH, S_JUMP, S_JAL, S_JR:
                  state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RESET;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_wr     = 1'b1;
        ctrl.alu_src_b = 2'd1;
        ctrl.alu_cntrl = ALU_ADD;
        ctrl.pc_wr     = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'd3;
        ctrl.alu_cntrl = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  ctrl.alu_cntrl = ALU_SUB;
          FN_SLT:  ctrl.alu_cntrl = ALU_SLT;
          default: ctrl.alu_cntrl = ALU_ADD;
        endcase
      end
      S_WB_R: ctrl.reg_wr = 1'b1;
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_cntrl = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_WB_I: begin
        ctrl.reg_dst = 2'd2;
        ctrl.reg_wr  = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_cntrl = ALU_ADD;
      end
      S_MEM_RD: ctrl.i_or_d = 1'b1;
      S_WB_MEM: begin
        ctrl.reg_dst    = 2'd2;
        ctrl.mem_to_reg = 2'd1;
        ctrl.reg_wr     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.i_or_d = 1'b1;
        ctrl.mem_wr = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_cntrl = ALU_SUB;
        ctrl.pc_src    = 2'd1;
        // Only Mealy term: take the branch target when the compare agrees.
        ctrl.pc_wr     = ((opcode == OP_BEQ) &&  zero) ||
                         ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        ctrl.pc_src = 2'd2;
        ctrl.pc_wr  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_src     = 2'd2;
        ctrl.pc_wr      = 1'b1;
        ctrl.reg_dst    = 2'd1;
        ctrl.mem_to_reg = 2'd2;
        ctrl.reg_wr     = 1'b1;
      end
      S_JR: begin
        ctrl.pc_src = 2'd3;
        ctrl.pc_wr  = 1'b1;
      end
      S_HALT:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign PCWr     = ctrl.pc_wr;
  assign IRWr     = ctrl.ir_wr;
  assign IorD     = ctrl.i_or_d;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUcntrl = ctrl.alu_cntrl;
  assign MemWr    = ctrl.mem_wr;
  assign MemToReg = ctrl.mem_to_reg;
  assign RegDst   = ctrl.reg_dst;
  assign RegWr    = ctrl.reg_wr;
  assign PCSrc    = ctrl.pc_src;
  assign illegal  = ctrl.illegal;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level reference model expands
// each instruction into its expected per-cycle control vector, and every
// cycle of the DUT is compared against it.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWr, IRWr, IorD, ALUSrcA, MemWr, RegWr, illegal;
  logic [1:0] ALUSrcB, MemToReg, RegDst, PCSrc;
  logic [2:0] ALUcntrl;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [17:0] obs;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUcntrl(ALUcntrl), .MemWr(MemWr),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWr(RegWr), .PCSrc(PCSrc),
    .illegal(illegal), .state(state)
  );

  assign obs = {PCWr, IRWr, IorD, ALUSrcA, ALUSrcB, ALUcntrl, MemWr,
                MemToReg, RegDst, RegWr, PCSrc, illegal};

  // Control vector in the same field order as obs.
  function automatic logic [17:0] mk(int pcwr, int irwr, int iord, int srca,
                                     int srcb, int alu, int memwr, int m2r,
                                     int rdst, int regwr, int pcs, int ill);
    return {pcwr[0], irwr[0], iord[0], srca[0], srcb[1:0], alu[2:0],
            memwr[0], m2r[1:0], rdst[1:0], regwr[0], pcs[1:0], ill[0]};
  endfunction

  // Reference model: expected cycle-by-cycle vectors for one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int alu;
    int taken;
    exp_q.delete();
    exp_q.push_back(mk(1,1,0,0,1,0, 0,0,0,0,0,0));   // fetch
    exp_q.push_back(mk(0,0,0,0,3,0, 0,0,0,0,0,0));   // decode
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      alu = (fn == 6'h22) ? 1 : (fn == 6'h2A) ? 3 : 0;
      exp_q.push_back(mk(0,0,0,1,0,alu, 0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,0));
    end else if (op == 6'h00 && fn == 6'h08) begin
      exp_q.push_back(mk(1,0,0,0,0,0, 0,0,0,0,3,0));
    end else if (op == 6'h08 || op == 6'h0E) begin
      exp_q.push_back(mk(0,0,0,1,2,(op == 6'h0E) ? 2 : 0, 0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0, 0,0,2,1,0,0));
    end else if (op == 6'h23) begin
      exp_q.push_back(mk(0,0,0,1,2,0, 0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,0,0,0,0, 0,1,2,1,0,0));
    end else if (op == 6'h2B) begin
      exp_q.push_back(mk(0,0,0,1,2,0, 0,0,0,0,0,0));
      exp_q.push_back(mk(0,0,1,0,0,0, 1,0,0,0,0,0));
    end else if (op == 6'h04 || op == 6'h05) begin
      taken = (op == 6'h04) ? int'(z) : int'(!z);
      exp_q.push_back(mk(taken,0,0,1,0,1, 0,0,0,0,1,0));
    end else if (op == 6'h02) begin
      exp_q.push_back(mk(1,0,0,0,0,0, 0,0,0,0,2,0));
    end else if (op == 6'h03) begin
      exp_q.push_back(mk(1,0,0,0,0,0, 0,2,1,1,2,0));
    end else begin
      for (int i = 0; i < 20; i++) exp_q.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    end
  endtask

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] got, input logic [3:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s state got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Called at a negedge just before the FETCH edge; checks n cycles.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n);
    opcode = op;
    funct  = fn;
    zero   = z;
    build(op, fn, z);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, i + 1), obs, exp_q[i]);
    end
  endtask

  task automatic run_all(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
    run(tag, op, fn, z, 32);
  endtask

  initial begin
    logic [5:0] rop, rfn;
    int sel;
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out", obs, 18'h0);
    check_state("reset", state, S_RESET);
    reset = 1'b0;

    run_all("add",  6'h00, 6'h20, 1'b0);
    run_all("sub",  6'h00, 6'h22, 1'b1);
    run_all("slt",  6'h00, 6'h2A, 1'b0);
    run_all("lw",   6'h23, 6'h15, 1'b0);
    run_all("sw",   6'h2B, 6'h00, 1'b1);
    run_all("beq1", 6'h04, 6'h00, 1'b1);
    run_all("beq0", 6'h04, 6'h00, 1'b0);
    run_all("bne0", 6'h05, 6'h00, 1'b0);
    run_all("bne1", 6'h05, 6'h00, 1'b1);
    run_all("jal",  6'h03, 6'h3F, 1'b0);
    run_all("j",    6'h02, 6'h00, 1'b0);
    run_all("jr",   6'h00, 6'h08, 1'b0);
    run_all("addi", 6'h08, 6'h22, 1'b0);
    run_all("xori", 6'h0E, 6'h00, 1'b1);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 12);
      rfn = 6'($urandom);
      case (sel)
        0: begin rop = 6'h00; rfn = 6'h20; end
        1: begin rop = 6'h00; rfn = 6'h22; end
        2: begin rop = 6'h00; rfn = 6'h2A; end
        3: begin rop = 6'h00; rfn = 6'h08; end
        4: rop = 6'h08;
        5: rop = 6'h0E;
        6: rop = 6'h23;
        7: rop = 6'h2B;
        8: rop = 6'h04;
        9: rop = 6'h05;
        10: rop = 6'h02;
        11: rop = 6'h03;
        default: rop = 6'h23;
      endcase
      run_all($sformatf("rnd%0d_op%02h", k, rop), rop, rfn, 1'($urandom));
    end

    // Reset during EXEC_R: outputs must drop before any clock edge.
    run("mid", 6'h00, 6'h20, 1'b0, 3);
    reset = 1'b1;
    #2;
    check("mid_reset_out", obs, 18'h0);
    check_state("mid_reset", state, S_RESET);
    @(negedge clk);
    check("mid_hold_out", obs, 18'h0);
    reset = 1'b0;
    run_all("post_reset_add", 6'h00, 6'h20, 1'b0);

    // Unsupported opcode: halt with no enables for 20 cycles.
    run_all("illegal", 6'h3F, 6'h00, 1'b0);
    check_state("halt", state, S_HALT);
    reset = 1'b1;
    #2;
    check("halt_reset_out", obs, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    run_all("final_lw", 6'h23, 6'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
